johnson_counter_param: RTL

Parametrised Johnson (twisted-ring) counter for WIDTH-bit state registers, producing 2×WIDTH states per cycle of the ring. It adds the following to the basic 4-bit up-only ring:
- count enable
- up/down direction
- synchronous load by state index
- binary index and one-hot phase decode
- a registered wrap pulse

It serves as the general phase/sequence generator for control paths and multi-phase enables.

---
 rtl/johnson_counter_param.sv | 109 ++++++++++
 1 files changed

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson (twisted-ring) counter.
// 2*WIDTH states per ring cycle, with enable, up/down stepping, load by state
// index, binary/one-hot decode of the current state, and registered wrap and
// load-error pulses.
module johnson_counter_param #(
    parameter int WIDTH = 4,
    parameter int IW    = $clog2(2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 dir,
    input  logic                 load,
    input  logic [IW-1:0]        load_idx,
    output logic [WIDTH-1:0]     q,
    output logic [IW-1:0]        idx,
    output logic [2*WIDTH-1:0]   phase,
    output logic                 wrap,
    output logic                 ld_err
);

    localparam int            N    = 2 * WIDTH;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             ld_err_q, ld_err_d;

    // Ring pattern for state index k: the first WIDTH+1 states fill ones in
    // from the MSB, the remaining states drain them out toward the LSB.
    function automatic logic [WIDTH-1:0] ring_pattern(input logic [IW-1:0] k);
        logic [WIDTH-1:0] p;
        int               kk;
        kk = int'(k);
        p  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (kk <= WIDTH) begin
                p[i] = (i >= WIDTH - kk);
            end else begin
                p[i] = (i < N - kk);
            end
        end
        return p;
    endfunction

    // Index of a legal ring pattern: with the MSB set the index equals the
    // number of ones; otherwise the ones are draining and the index counts
    // back from N.
    function automatic logic [IW-1:0] ring_index(input logic [WIDTH-1:0] s);
        int ones;
        ones = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + int'(s[i]);
        end
        if (s[WIDTH-1]) begin
            return IW'(ones);
        end else if (ones == 0) begin
            return '0;
        end else begin
            return IW'(N - ones);
        end
    endfunction

    // Decode is purely a function of the held state.
    always_comb begin
        idx   = ring_index(q_q);
        phase = {{(N-1){1'b0}}, 1'b1} << idx;
    end

    // Next-state selection: load beats stepping; an out-of-range load holds.
    always_comb begin
        q_d      = q_q;
        wrap_d   = 1'b0;
        ld_err_d = 1'b0;
        if (load) begin
            if (int'(load_idx) < N) begin
                q_d = ring_pattern(load_idx);
            end else begin
                ld_err_d = 1'b1;
            end
        end else if (en) begin
            if (!dir) begin
                q_d    = {~q_q[0], q_q[WIDTH-1:1]};
                wrap_d = (idx == LAST);
            end else begin
                q_d    = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
                wrap_d = (idx == '0);
            end
        end
    end

    // State and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q      <= '0;
            wrap_q   <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            wrap_q   <= wrap_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign q      = q_q;
    assign wrap   = wrap_q;
    assign ld_err = ld_err_q;

endmodule
